// File: rtl/pa_lsu_sram_seq_pkg.sv
// Shared sizing and FSM encoding for the LSU SRAM sequencer.
// The SRAM geometry and the state type live here so the sequencer and its parent agree.
package pa_lsu_sram_seq_pkg;

    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 4;
    localparam int DEPTH      = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_READY = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/pa_lsu_sram_seq.sv
// LSU SRAM sequencer: clears the array after reset and on flush, then arbitrates
// single-cycle read/write requests onto the SRAM pins with a one-cycle read return.
module pa_lsu_sram_seq #(
    parameter int ADDR_WIDTH = pa_lsu_sram_seq_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = pa_lsu_sram_seq_pkg::DATA_WIDTH,
    parameter int DEPTH      = pa_lsu_sram_seq_pkg::DEPTH
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  req_rdy,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  init_busy,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    import pa_lsu_sram_seq_pkg::*;

    state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  sweep, last, accept;

    assign sweep  = (state == ST_INIT) || (state == ST_FLUSH);
    assign last   = (cnt == ADDR_WIDTH'(DEPTH - 1));
    assign accept = req_vld & req_rdy;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rd_vld     <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rd_vld     <= accept & ~req_wr;
            // Only a flush sweep ending signals completion; the power-on clear is silent.
            flush_done <= (state == ST_FLUSH) & last;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE:  state_nxt = ST_INIT;
            ST_INIT, ST_FLUSH: begin
                if (last) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + ADDR_WIDTH'(1);
                end
            end
            ST_READY: if (flush_req) state_nxt = ST_FLUSH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Flush wins over a request arriving in the same cycle.
    assign req_rdy   = (state == ST_READY) & ~flush_req;
    assign init_busy = (state != ST_READY);
    assign rd_data   = rd_vld ? sram_q : '0;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (sweep) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = cnt;
        end else if (accept) begin
            if (!req_wr) begin
                sram_cen = 1'b0;
                sram_a   = req_addr;
            end else if (req_wmask != '0) begin
                // An all-zero mask still handshakes but leaves the SRAM idle.
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = ~req_wmask;
                sram_a    = req_addr;
                sram_d    = req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_pa_lsu_sram_seq.sv
// Self-checking bench for pa_lsu_sram_seq: behavioural SRAM plus a reference memory
// image updated from the issued transactions.
module tb_pa_lsu_sram_seq;
    localparam int AW = 7;
    localparam int DW = 4;
    localparam int DEPTH = 128;

    logic          forever_cpuclk = 1'b0;
    logic          cpurst_b;
    logic          req_vld, req_wr, flush_req;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, req_wmask;
    logic          req_rdy, rd_vld, flush_done, init_busy;
    logic [DW-1:0] rd_data, sram_d, sram_wen, sram_q;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;

    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];
    int n_checks, n_fail;

    always #5 forever_cpuclk = ~forever_cpuclk;

    pa_lsu_sram_seq dut (
        .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b),
        .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_rdy(req_rdy),
        .rd_vld(rd_vld), .rd_data(rd_data), .flush_req(flush_req),
        .flush_done(flush_done), .init_busy(init_busy), .sram_a(sram_a),
        .sram_d(sram_d), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_q(sram_q)
    );

    // Behavioural SRAM: bit-masked write, read data on the following cycle.
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= sram_mem[sram_a];
        end
    end

    function automatic logic [16:0] pins();
        return {sram_cen, sram_gwen, sram_wen, sram_a, sram_d};
    endfunction

    localparam logic [16:0] PINS_IDLE = {1'b1, 1'b1, 4'hF, 7'd0, 4'h0};

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
        @(posedge forever_cpuclk); #1;
        req_vld = v; req_wr = w; req_addr = a; req_wdata = d; req_wmask = m;
    endtask

    task automatic test_reset();
        cpurst_b = 1'b1; req_vld = 0; req_wr = 0; req_addr = '0; req_wdata = '0;
        req_wmask = '0; flush_req = 0;
        #2 cpurst_b = 1'b0;
        #10;
        n_checks++; if (pins() !== PINS_IDLE) begin n_fail++; $display("FAIL reset_pins: got %h expected %h", pins(), PINS_IDLE); end
        n_checks++; if ({init_busy, req_rdy, rd_vld, flush_done} !== 4'b1000) begin n_fail++;
            $display("FAIL reset_ctrl: got busy/rdy/rdvld/fdone=%b expected 1000", {init_busy, req_rdy, rd_vld, flush_done}); end
        n_checks++; if (rd_data !== 4'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    endtask

    // Releases reset just after an edge, then walks IDLE, the 128-entry clear and the first READY cycle.
    task automatic test_init_sweep();
        @(posedge forever_cpuclk); #1 cpurst_b = 1'b1;
        @(negedge forever_cpuclk);
        n_checks++; if (pins() !== PINS_IDLE || init_busy !== 1'b1) begin n_fail++;
            $display("FAIL init_idle: got pins %h busy %b expected %h busy 1", pins(), init_busy, PINS_IDLE); end
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge forever_cpuclk);
            n_checks++; if (pins() !== {1'b0, 1'b0, 4'h0, 7'(i), 4'h0} || init_busy !== 1'b1 || req_rdy !== 1'b0) begin
                n_fail++; $display("FAIL init_clear[%0d]: got pins %h busy %b rdy %b", i, pins(), init_busy, req_rdy); end
            n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL init_no_fdone[%0d]: got %b expected 0", i, flush_done); end
        end
        @(negedge forever_cpuclk);
        n_checks++; if ({req_rdy, init_busy, flush_done} !== 3'b100) begin n_fail++;
            $display("FAIL init_ready: got rdy/busy/fdone=%b expected 100", {req_rdy, init_busy, flush_done}); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] exp;
        drive(1, 1, 7'd5, 4'hA, 4'hF);
        @(negedge forever_cpuclk);
        n_checks++; if (pins() !== {1'b0, 1'b0, 4'h0, 7'd5, 4'hA} || req_rdy !== 1'b1) begin n_fail++;
            $display("FAIL wr5_pins: got %h rdy %b expected %h", pins(), req_rdy, {1'b0, 1'b0, 4'h0, 7'd5, 4'hA}); end
        ref_mem[5] = 4'hA;
        drive(1, 0, 7'd5, 4'h0, 4'h0);
        @(negedge forever_cpuclk);
        n_checks++; if (pins() !== {1'b0, 1'b1, 4'hF, 7'd5, 4'h0} || rd_vld !== 1'b0) begin n_fail++;
            $display("FAIL rd5_pins: got %h rdvld %b", pins(), rd_vld); end
        drive(0, 0, 7'd0, 4'h0, 4'h0);
        @(negedge forever_cpuclk);
        n_checks++; if (rd_vld !== 1'b1 || rd_data !== ref_mem[5]) begin n_fail++;
            $display("FAIL rd5_data: got vld %b data %h expected 1 %h", rd_vld, rd_data, ref_mem[5]); end
        exp = (ref_mem[9] & ~4'b0101) | (4'hF & 4'b0101);
        drive(1, 1, 7'd9, 4'hF, 4'b0101);
        @(negedge forever_cpuclk);
        n_checks++; if (pins() !== {1'b0, 1'b0, 4'b1010, 7'd9, 4'hF}) begin n_fail++;
            $display("FAIL wr9_pins: got %h expected %h", pins(), {1'b0, 1'b0, 4'b1010, 7'd9, 4'hF}); end
        ref_mem[9] = exp;
        drive(1, 1, 7'd9, 4'h0, 4'h0);
        @(negedge forever_cpuclk);
        n_checks++; if (pins() !== PINS_IDLE || req_rdy !== 1'b1) begin n_fail++;
            $display("FAIL wr_mask0: got pins %h rdy %b expected %h rdy 1", pins(), req_rdy, PINS_IDLE); end
        drive(1, 0, 7'd9, 4'h0, 4'h0);
        drive(0, 0, 7'd0, 4'h0, 4'h0);
        @(negedge forever_cpuclk);
        n_checks++; if (rd_vld !== 1'b1 || rd_data !== exp) begin n_fail++;
            $display("FAIL rd9_data: got vld %b data %h expected 1 %h", rd_vld, rd_data, exp); end
    endtask

    task automatic test_flush();
        drive(1, 0, 7'd5, 4'h0, 4'h0);
        // Flush and a write collide: the write must be refused.
        drive(1, 1, 7'd3, 4'hF, 4'hF);
        flush_req = 1'b1;
        @(negedge forever_cpuclk);
        n_checks++; if (req_rdy !== 1'b0 || pins() !== PINS_IDLE) begin n_fail++;
            $display("FAIL flush_prio: got rdy %b pins %h expected 0 %h", req_rdy, pins(), PINS_IDLE); end
        n_checks++; if (rd_vld !== 1'b1 || rd_data !== ref_mem[5]) begin n_fail++;
            $display("FAIL rd_before_flush: got vld %b data %h expected 1 %h", rd_vld, rd_data, ref_mem[5]); end
        @(posedge forever_cpuclk); #1;
        flush_req = 1'b0; req_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge forever_cpuclk);
            n_checks++; if (pins() !== {1'b0, 1'b0, 4'h0, 7'(i), 4'h0} || {init_busy, req_rdy, flush_done} !== 3'b100) begin
                n_fail++; $display("FAIL flush_clear[%0d]: got pins %h busy/rdy/fdone %b", i, pins(), {init_busy, req_rdy, flush_done}); end
            if (i == 40) flush_req = 1'b1;
            if (i == 41) flush_req = 1'b0;
        end
        @(negedge forever_cpuclk);
        n_checks++; if ({flush_done, req_rdy, init_busy} !== 3'b110) begin n_fail++;
            $display("FAIL flush_done: got fdone/rdy/busy=%b expected 110", {flush_done, req_rdy, init_busy}); end
        @(negedge forever_cpuclk);
        n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL flush_done_pulse: got %b expected 0", flush_done); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int k = 0; k < 4; k++) begin
            logic [AW-1:0] a;
            a = (k == 0) ? 7'd5 : (k == 1) ? 7'd3 : 7'($urandom_range(0, DEPTH - 1));
            drive(1, 0, a, 4'h0, 4'h0);
            drive(0, 0, 7'd0, 4'h0, 4'h0);
            @(negedge forever_cpuclk);
            n_checks++; if (rd_vld !== 1'b1 || rd_data !== 4'h0) begin n_fail++;
                $display("FAIL post_flush_rd[%0d]: got vld %b data %h expected 1 0", a, rd_vld, rd_data); end
        end
    endtask

    task automatic test_random_traffic();
        logic          pend;
        logic [DW-1:0] pend_data;
        pend = 1'b0; pend_data = '0;
        for (int n = 0; n < 400; n++) begin
            logic v, w;
            logic [AW-1:0] a;
            logic [DW-1:0] d, m;
            logic [16:0] exp_pins;
            v = ($urandom % 4) != 0;
            w = $urandom % 2;
            a = (n % 8 == 0) ? 7'($urandom_range(0, DEPTH - 1)) : 7'($urandom % 16);
            d = 4'($urandom);
            m = 4'($urandom);
            drive(v, w, a, d, m);
            @(negedge forever_cpuclk);
            n_checks++; if (rd_vld !== pend || rd_data !== (pend ? pend_data : 4'h0)) begin n_fail++;
                $display("FAIL rand_rd[%0d]: got vld %b data %h expected %b %h", n, rd_vld, rd_data, pend, pend ? pend_data : 4'h0); end
            if (!v)        exp_pins = PINS_IDLE;
            else if (!w)   exp_pins = {1'b0, 1'b1, 4'hF, a, 4'h0};
            else if (m == 0) exp_pins = PINS_IDLE;
            else           exp_pins = {1'b0, 1'b0, ~m, a, d};
            n_checks++; if (pins() !== exp_pins || req_rdy !== 1'b1) begin n_fail++;
                $display("FAIL rand_pins[%0d]: got %h rdy %b expected %h rdy 1", n, pins(), req_rdy, exp_pins); end
            pend = v & ~w;
            if (pend) pend_data = ref_mem[a];
            if (v && w) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
        end
        drive(0, 0, 7'd0, 4'h0, 4'h0);
        @(negedge forever_cpuclk);
        n_checks++; if (rd_vld !== pend || rd_data !== (pend ? pend_data : 4'h0)) begin n_fail++;
            $display("FAIL rand_rd_tail: got vld %b data %h expected %b %h", rd_vld, rd_data, pend, pend ? pend_data : 4'h0); end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 7'd5, 4'h0, 4'h0);
        @(posedge forever_cpuclk); #1;
        req_vld = 1'b0;
        n_checks++; if (rd_vld !== 1'b1) begin n_fail++; $display("FAIL mid_rd_pending: got %b expected 1", rd_vld); end
        cpurst_b = 1'b0;
        #1;
        n_checks++; if ({rd_vld, rd_data} !== 5'b0 || {init_busy, req_rdy, flush_done} !== 3'b100 || pins() !== PINS_IDLE) begin
            n_fail++; $display("FAIL mid_rd_reset: got vld %b data %h busy/rdy/fdone %b pins %h", rd_vld, rd_data, {init_busy, req_rdy, flush_done}, pins()); end
        @(posedge forever_cpuclk); #1 cpurst_b = 1'b1;
        @(negedge forever_cpuclk);
        for (int i = 0; i <= 60; i++) begin
            @(negedge forever_cpuclk);
            n_checks++; if (pins() !== {1'b0, 1'b0, 4'h0, 7'(i), 4'h0}) begin n_fail++;
                $display("FAIL mid_sweep[%0d]: got %h", i, pins()); end
        end
        #1 cpurst_b = 1'b0;
        #1;
        n_checks++; if (pins() !== PINS_IDLE || {init_busy, req_rdy, rd_vld, flush_done} !== 4'b1000) begin n_fail++;
            $display("FAIL mid_init_reset: got pins %h busy/rdy/rdvld/fdone %b", pins(), {init_busy, req_rdy, rd_vld, flush_done}); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] <= 4'($urandom);
        sram_q <= 4'hF;
    end

    initial begin
        n_checks = 0; n_fail = 0;
        test_reset();
        test_init_sweep();
        test_write_read();
        test_flush();
        test_random_traffic();
        test_reset_mid();
        test_init_sweep();
        test_write_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/pa_lsu_sram_seq.md
PA_LSU_SRAM_SEQ -- requirements
Module: pa_lsu_sram_seq

Interface
REQ-001 Parameter ADDR_WIDTH, 7, SRAM address width.
REQ-002 Parameter DATA_WIDTH, 4, SRAM data width and per-bit write-enable width.
REQ-003 Parameter DEPTH, 128, entry count (2^ADDR_WIDTH).
REQ-004 forever_cpuclk  in  1  single clock; all state on its rising edge.
REQ-005 cpurst_b  in  1  reset, asynchronous, active-low.
REQ-006 req_vld  in  1  access request valid.
REQ-007 req_wr  in  1  1=write, 0=read.
REQ-008 req_addr  in  ADDR_WIDTH  entry index.
REQ-009 req_wdata  in  DATA_WIDTH  write data.
REQ-010 req_wmask  in  DATA_WIDTH  active-high per-bit write mask.
REQ-011 req_rdy  out  1  request accepted when req_vld&req_rdy.
REQ-012 rd_vld  out  1  read data valid pulse.
REQ-013 rd_data  out  DATA_WIDTH  read data.
REQ-014 flush_req  in  1  request to clear all entries.
REQ-015 flush_done  out  1  one-cycle pulse at flush completion.
REQ-016 init_busy  out  1  high while in IDLE, INIT or FLUSH.
REQ-017 sram_a / sram_d  out  ADDR_WIDTH / DATA_WIDTH  SRAM address / write data.
REQ-018 sram_cen, sram_gwen  out  1  SRAM chip enable / global write enable, both active-low.
REQ-019 sram_wen  out  DATA_WIDTH  SRAM per-bit write enable, active-low.
REQ-020 sram_q  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access.

Function
REQ-021 FSM states IDLE, INIT, READY, FLUSH; IDLE->INIT unconditionally on first edge after reset release.
REQ-022 INIT/FLUSH: one clear write per cycle, cnt 0..DEPTH-1; sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=cnt.
REQ-023 Clear sweep is exactly DEPTH cycles; edge at cnt==DEPTH-1 moves to READY and zeroes cnt; no cnt wrap-around write.
REQ-024 READY & flush_req=1 -> FLUSH next edge; flush_req ignored in IDLE, INIT and FLUSH (not queued).
REQ-025 flush_done=1 for the single cycle after FLUSH->READY; INIT completion does not pulse flush_done.
REQ-026 req_rdy = (state==READY) & ~flush_req; flush has priority over a simultaneous request.
REQ-027 Accepted read, cycle N: sram_cen=0, sram_gwen=1, sram_wen=all 1, sram_a=req_addr; rd_vld=1 at N+1, rd_data=sram_q at N+1.
REQ-028 Accepted write: sram_cen=0, sram_gwen=0, sram_wen=~req_wmask, sram_d=req_wdata, sram_a=req_addr; no rd_vld.
REQ-029 Accepted write with req_wmask=0: handshake completes, sram_cen=1 (no SRAM access).
REQ-030 No access: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
REQ-031 Back-to-back accepts every cycle in READY; write at N then read same address at N+1 returns written bits at N+2.
REQ-032 Read accepted in the last READY cycle before FLUSH still produces rd_vld next cycle.
REQ-033 rd_data=0 when rd_vld=0.

Reset
REQ-034 Assertion of cpurst_b forces immediately: state=IDLE, cnt=0, rd_vld=0, flush_done=0, req_rdy=0, init_busy=1, SRAM outputs per REQ-030.
REQ-035 Reset mid-INIT/FLUSH/read abandons operation; full INIT sweep restarts from entry 0 after release.

Structure
REQ-036 Shared package holds ADDR_WIDTH, DATA_WIDTH, DEPTH and the 2-bit FSM state encoding.
REQ-037 Single flat module (FSM, clear counter, rd_vld flop); no sub-module; SRAM instantiated by parent.

Verification
REQ-038 Release reset -> IDLE 1 cycle, 128 clear writes to addresses 0..127, req_rdy=1 on cycle 130, init_busy falls same cycle.
REQ-039 Write addr 5 data 4'hA mask 4'hF, then read addr 5 -> sram_wen=4'h0, rd_vld at N+1 with rd_data=4'hA.
REQ-040 Write addr 9 data 4'hF mask 4'b0101 over 0 -> read addr 9 returns 4'h5; mask 0 write shows sram_cen=1.
REQ-041 flush_req and req_vld same READY cycle -> req_rdy=0, FLUSH 128 cycles, flush_done pulse once, then read any address returns 0.
REQ-042 Assert cpurst_b at INIT cnt=60 -> outputs at reset values immediately; after release sweep restarts at address 0.
